// File: rtl/dff_pipe.sv
// Multi-stage registered pipeline with valid/ready flow control.
// Empty stages absorb words even while downstream stalls, so all DEPTH stages can hold data.
module dff_pipe #(
   parameter int unsigned      WIDTH   = 8,
   parameter int unsigned      DEPTH   = 4,
   parameter logic [WIDTH-1:0] RST_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         flush,
   input  logic                         in_valid,
   output logic                         in_ready,
   input  logic [WIDTH-1:0]             in_data,
   output logic                         out_valid,
   input  logic                         out_ready,
   output logic [WIDTH-1:0]             out_data,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy
);

   localparam int unsigned OCC_W = $clog2(DEPTH + 1);

   logic [DEPTH-1:0] v_q;
   logic [DEPTH-1:0] v_d;
   logic [DEPTH-1:0] rdy;
   logic [DEPTH-1:0] ld;
   logic [DEPTH-1:0] up_valid;
   logic [WIDTH-1:0] d_q      [DEPTH];
   logic [WIDTH-1:0] d_d      [DEPTH];
   logic [WIDTH-1:0] up_data  [DEPTH];
   logic [OCC_W-1:0] occ_q;
   logic [OCC_W-1:0] occ_d;
   logic             in_acc;
   logic             out_acc;

   // Ready ripples from the output side back to stage 0: a stage can take a
   // word if it is empty or if the stage after it can move this cycle.
   always_comb begin
      logic carry;
      carry = out_ready;
      rdy   = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         carry  = !v_q[i] || carry;
         rdy[i] = carry;
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign up_valid[gi] = in_valid;
            assign up_data[gi]  = in_data;
         end else begin : g_body
            assign up_valid[gi] = v_q[gi-1];
            assign up_data[gi]  = d_q[gi-1];
         end

         // Flush blocks every load so data words hold while valids clear.
         assign ld[gi]  = rdy[gi] && up_valid[gi] && !flush;
         assign v_d[gi] = flush ? 1'b0 : (rdy[gi] ? up_valid[gi] : v_q[gi]);
         assign d_d[gi] = ld[gi] ? up_data[gi] : d_q[gi];

         always_ff @(posedge clk) begin
            if (rst) begin
               v_q[gi] <= 1'b0;
               d_q[gi] <= RST_VAL;
            end else begin
               v_q[gi] <= v_d[gi];
               d_q[gi] <= d_d[gi];
            end
         end
      end
   endgenerate

   assign in_ready  = rdy[0] && !flush;
   assign out_valid = v_q[DEPTH-1] && !flush;
   assign out_data  = d_q[DEPTH-1];

   assign in_acc  = in_valid && in_ready;
   assign out_acc = out_valid && out_ready;

   // Count tracks accepts directly instead of summing the valid vector.
   always_comb begin
      occ_d = occ_q;
      if (flush) begin
         occ_d = '0;
      end else if (in_acc && !out_acc) begin
         occ_d = occ_q + OCC_W'(1);
      end else if (!in_acc && out_acc) begin
         occ_d = occ_q - OCC_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         occ_q <= '0;
      end else begin
         occ_q <= occ_d;
      end
   end

   assign occupancy = occ_q;

endmodule
